// File: rtl/tlb_lookup_sched.sv
// Round-robin I/D translation scheduler that probes the TLB array one entry per cycle.
// Optional feature macro TLB_LOOKUP_MRU_EN: each side probes its last-hit index first.

module tlb_lookup_sched #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [31:0]      i_ea,
  input  logic             i_as,
  output logic             i_ack,
  input  logic             d_req,
  input  logic [31:0]      d_ea,
  input  logic             d_as,
  input  logic             d_store,
  output logic             d_ack,
  input  logic             tlb_lock,
  output logic [31:0]      lk_ea,
  output logic             lk_as,
  output logic             lk_ifetch,
  output logic             lk_store,
  output logic             lk_load,
  output logic [IDX_W-1:0] lk_idx,
  input  logic             lk_hit,
  input  logic [4:0]       lk_exc,
  output logic             rsp_valid,
  output logic             rsp_src,
  output logic             rsp_miss,
  output logic [IDX_W-1:0] rsp_idx,
  output logic [4:0]       rsp_exc,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_rrPtr;
  logic             r_side;
  logic [IDX_W-1:0] r_resIdx;
  logic [4:0]       r_resExc;
  logic             r_resMiss;
  logic             w_grantI;
  logic             w_grantD;
  logic             w_hit;
  logic             w_miss;
  logic             w_step;
  logic             w_mruProbe;
  logic [IDX_W-1:0] w_startIdx;

`ifdef TLB_LOOKUP_MRU_EN
  logic             r_mruPhase;
  logic [IDX_W-1:0] r_mruI;
  logic [IDX_W-1:0] r_mruD;

  assign w_mruProbe = r_mruPhase;
  assign w_startIdx = w_grantD ? r_mruD : r_mruI;

  // A missed MRU probe restarts the full scan at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mruPhase <= 1'b0;
      r_mruI     <= '0;
      r_mruD     <= '0;
    end else begin
      if (w_grantI || w_grantD) begin
        r_mruPhase <= 1'b1;
      end else if (r_state == SCAN && !tlb_lock) begin
        r_mruPhase <= 1'b0;
      end
      if (w_hit) begin
        if (r_side) r_mruD <= lk_idx;
        else        r_mruI <= lk_idx;
      end
    end
  end
`else
  assign w_mruProbe = 1'b0;
  assign w_startIdx = '0;
`endif

  always_comb begin
    w_nextState = r_state;
    w_grantI    = 1'b0;
    w_grantD    = 1'b0;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!tlb_lock && (i_req || d_req)) begin
          if (i_req && d_req) begin
            w_grantD = r_rrPtr;
            w_grantI = ~r_rrPtr;
          end else begin
            w_grantI = i_req;
            w_grantD = d_req;
          end
          w_nextState = SCAN;
        end
      end
      SCAN: begin
        // A write in progress freezes the probe and masks the judge.
        if (!tlb_lock) begin
          if (lk_hit) begin
            w_hit       = 1'b1;
            w_nextState = DONE;
          end else if (!w_mruProbe && lk_idx == LAST_IDX) begin
            w_miss      = 1'b1;
            w_nextState = DONE;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rrPtr   <= 1'b0;
      r_side    <= 1'b0;
      r_resIdx  <= '0;
      r_resExc  <= '0;
      r_resMiss <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      lk_ea     <= '0;
      lk_as     <= 1'b0;
      lk_ifetch <= 1'b0;
      lk_store  <= 1'b0;
      lk_load   <= 1'b0;
      lk_idx    <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_src   <= 1'b0;
      rsp_miss  <= 1'b0;
      rsp_idx   <= '0;
      rsp_exc   <= '0;
    end else begin
      r_state   <= w_nextState;
      i_ack     <= w_grantI;
      d_ack     <= w_grantD;
      rsp_valid <= 1'b0;
      if (w_grantI || w_grantD) begin
        r_rrPtr   <= w_grantI;
        r_side    <= w_grantD;
        lk_ea     <= w_grantD ? d_ea : i_ea;
        lk_as     <= w_grantD ? d_as : i_as;
        lk_ifetch <= w_grantI;
        lk_store  <= w_grantD & d_store;
        lk_load   <= w_grantD & ~d_store;
        lk_idx    <= w_startIdx;
        busy      <= 1'b1;
      end
      if (w_step) begin
        lk_idx <= w_mruProbe ? '0 : lk_idx + 1'b1;
      end
      if (w_hit) begin
        r_resIdx  <= lk_idx;
        r_resExc  <= lk_exc;
        r_resMiss <= 1'b0;
      end
      if (w_miss) begin
        r_resIdx  <= '0;
        r_resExc  <= '0;
        r_resMiss <= 1'b1;
      end
      if (w_hit || w_miss) begin
        busy      <= 1'b0;
        lk_ifetch <= 1'b0;
        lk_store  <= 1'b0;
        lk_load   <= 1'b0;
      end
      // Response fields are published together so they hold until the next lookup ends.
      if (r_state == DONE) begin
        rsp_valid <= 1'b1;
        rsp_src   <= r_side;
        rsp_miss  <= r_resMiss;
        rsp_idx   <= r_resIdx;
        rsp_exc   <= r_resExc;
      end
    end
  end

endmodule

// File: tb/tb_tlb_lookup_sched.sv
// Scoreboard bench for tlb_lookup_sched: expected responses queued at ack, checked on rsp_valid.

module tb_tlb_lookup_sched;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;

  logic             clk;
  logic             rst;
  logic             i_req;
  logic [31:0]      i_ea;
  logic             i_as;
  logic             i_ack;
  logic             d_req;
  logic [31:0]      d_ea;
  logic             d_as;
  logic             d_store;
  logic             d_ack;
  logic             tlb_lock;
  logic [31:0]      lk_ea;
  logic             lk_as;
  logic             lk_ifetch;
  logic             lk_store;
  logic             lk_load;
  logic [IDX_W-1:0] lk_idx;
  logic             lk_hit;
  logic [4:0]       lk_exc;
  logic             rsp_valid;
  logic             rsp_src;
  logic             rsp_miss;
  logic [IDX_W-1:0] rsp_idx;
  logic [4:0]       rsp_exc;
  logic             busy;

  logic             hitEnable;
  logic [IDX_W-1:0] hitIdx;
  logic [4:0]       hitExc;

  typedef struct {
    logic             src;
    logic             miss;
    logic [IDX_W-1:0] idx;
    logic [4:0]       exc;
    int               due;
  } exp_t;

  exp_t expQ[$];
  int   checks;
  int   failures;
  int   cycle;

  tlb_lookup_sched #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_ea(i_ea), .i_as(i_as), .i_ack(i_ack),
    .d_req(d_req), .d_ea(d_ea), .d_as(d_as), .d_store(d_store), .d_ack(d_ack),
    .tlb_lock(tlb_lock),
    .lk_ea(lk_ea), .lk_as(lk_as), .lk_ifetch(lk_ifetch), .lk_store(lk_store),
    .lk_load(lk_load), .lk_idx(lk_idx), .lk_hit(lk_hit), .lk_exc(lk_exc),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_miss(rsp_miss),
    .rsp_idx(rsp_idx), .rsp_exc(rsp_exc), .busy(busy)
  );

  // Hit-judge model: a single matching entry, answered combinationally.
  assign lk_hit = hitEnable && (lk_idx == hitIdx);
  assign lk_exc = hitExc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle++;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rsp at cycle %0d got rsp_valid=1 need 0", cycle);
      end else begin
        e = expQ.pop_front();
        checks++;
        if (cycle !== e.due) begin
          failures++;
          $display("[TB] FAIL rsp_cycle got %0d need %0d", cycle, e.due);
        end
        checks++;
        if (rsp_src !== e.src) begin
          failures++;
          $display("[TB] FAIL rsp_src got %0b need %0b", rsp_src, e.src);
        end
        checks++;
        if (rsp_miss !== e.miss) begin
          failures++;
          $display("[TB] FAIL rsp_miss got %0b need %0b", rsp_miss, e.miss);
        end
        checks++;
        if (rsp_idx !== e.idx) begin
          failures++;
          $display("[TB] FAIL rsp_idx got %0d need %0d", rsp_idx, e.idx);
        end
        checks++;
        if (rsp_exc !== e.exc) begin
          failures++;
          $display("[TB] FAIL rsp_exc got %h need %h", rsp_exc, e.exc);
        end
      end
    end
  end

  task automatic pushExp(input logic src, input logic miss, input logic [IDX_W-1:0] idx,
                         input logic [4:0] exc, input int due);
    exp_t e;
    e.src  = src;
    e.miss = miss;
    e.idx  = idx;
    e.exc  = exc;
    e.due  = due;
    expQ.push_back(e);
  endtask

  task automatic waitAck(input logic side, output int ackCycle, output bit ok);
    ok       = 1'b0;
    ackCycle = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (side ? d_ack : i_ack) begin
        ackCycle = cycle;
        ok       = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL ack_timeout side=%0b got no ack need ack within 20 cycles", side);
    end
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 150; n++) begin
      if (expQ.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout got %0d pending need 0", expQ.size());
      expQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({i_ack, d_ack, rsp_valid, rsp_src, rsp_miss, busy} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got %b need 000000",
               {i_ack, d_ack, rsp_valid, rsp_src, rsp_miss, busy});
    end
    checks++;
    if ({lk_ifetch, lk_store, lk_load, lk_as} !== 4'b0 || lk_ea !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_lk got ctl=%b ea=%h need 0000/0",
               {lk_ifetch, lk_store, lk_load, lk_as}, lk_ea);
    end
    checks++;
    if (lk_idx !== '0 || rsp_idx !== '0 || rsp_exc !== 5'h0) begin
      failures++;
      $display("[TB] FAIL reset_idx got lk_idx=%0d rsp_idx=%0d rsp_exc=%h need 0",
               lk_idx, rsp_idx, rsp_exc);
    end
    rst = 1'b0;
  endtask

  task automatic test_ifetch_hit();
    int t;
    bit ok;
    @(negedge clk);
    hitEnable = 1'b1;
    hitIdx    = 6'd5;
    hitExc    = 5'h00;
    i_ea      = 32'h0000_1000;
    i_as      = 1'b1;
    i_req     = 1'b1;
    waitAck(1'b0, t, ok);
    i_req = 1'b0;
    if (ok) begin
      pushExp(1'b0, 1'b0, 6'd5, 5'h00, t + 7);
      checks++;
      if (lk_ea !== 32'h0000_1000 || lk_as !== 1'b1) begin
        failures++;
        $display("[TB] FAIL ifetch_addr got ea=%h as=%b need 00001000/1", lk_ea, lk_as);
      end
      checks++;
      if ({lk_ifetch, lk_store, lk_load, busy} !== 4'b1001 || lk_idx !== 6'd0) begin
        failures++;
        $display("[TB] FAIL ifetch_ctl got ifs_l_busy=%b idx=%0d need 1001/0",
                 {lk_ifetch, lk_store, lk_load, busy}, lk_idx);
      end
    end
    waitDrain();
  endtask

  task automatic test_data_side();
    int t;
    bit ok;
    @(negedge clk);
    hitEnable = 1'b0;
    d_ea      = 32'hDEAD_B000;
    d_as      = 1'b1;
    d_store   = 1'b1;
    d_req     = 1'b1;
    waitAck(1'b1, t, ok);
    d_req = 1'b0;
    if (ok) begin
      pushExp(1'b1, 1'b1, 6'd0, 5'h00, t + ENTRIES + 1);
      repeat (30) @(negedge clk);
      checks++;
      if ({lk_ifetch, lk_store, lk_load} !== 3'b010 || lk_idx !== 6'd30) begin
        failures++;
        $display("[TB] FAIL store_scan got ifs_l=%b idx=%0d need 010/30",
                 {lk_ifetch, lk_store, lk_load}, lk_idx);
      end
    end
    waitDrain();
    checks++;
    if ({lk_ifetch, lk_store, lk_load, busy} !== 4'b0) begin
      failures++;
      $display("[TB] FAIL done_clear got %b need 0000", {lk_ifetch, lk_store, lk_load, busy});
    end

    hitEnable = 1'b1;
    hitIdx    = 6'd0;
    hitExc    = 5'h1F;
    d_store   = 1'b0;
    d_req     = 1'b1;
    waitAck(1'b1, t, ok);
    d_req = 1'b0;
    if (ok) begin
      pushExp(1'b1, 1'b0, 6'd0, 5'h1F, t + 2);
      checks++;
      if ({lk_ifetch, lk_store, lk_load} !== 3'b001 || lk_ea !== 32'hDEAD_B000) begin
        failures++;
        $display("[TB] FAIL load_ctl got ifs_l=%b ea=%h need 001/deadb000",
                 {lk_ifetch, lk_store, lk_load}, lk_ea);
      end
    end
    waitDrain();

    hitIdx = 6'(ENTRIES - 1);
    hitExc = 5'h0A;
    i_req  = 1'b1;
    waitAck(1'b0, t, ok);
    i_req = 1'b0;
    if (ok) pushExp(1'b0, 1'b0, 6'(ENTRIES - 1), 5'h0A, t + ENTRIES + 1);
    waitDrain();
  endtask

  task automatic test_lock();
    int t;
    bit ok;
    @(negedge clk);
    hitEnable = 1'b1;
    hitIdx    = 6'd1;
    hitExc    = 5'h02;
    d_store   = 1'b0;
    tlb_lock  = 1'b1;
    d_req     = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if (d_ack !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL lock_idle_grant got ack=%b busy=%b need 0/0", d_ack, busy);
      end
    end
    tlb_lock = 1'b0;
    @(negedge clk);
    t = cycle;
    d_req = 1'b0;
    checks++;
    if (d_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lock_release_ack got %b need 1", d_ack);
    end else begin
      pushExp(1'b1, 1'b0, 6'd1, 5'h02, t + 3);
    end
    waitDrain();

    hitIdx = 6'd4;
    hitExc = 5'h00;
    i_req  = 1'b1;
    waitAck(1'b0, t, ok);
    i_req = 1'b0;
    if (ok) begin
      pushExp(1'b0, 1'b0, 6'd4, 5'h00, t + 9);
      repeat (2) @(negedge clk);
      tlb_lock = 1'b1;
      for (int n = 0; n < 3; n++) begin
        @(negedge clk);
        checks++;
        if (lk_idx !== 6'd2) begin
          failures++;
          $display("[TB] FAIL lock_hold_idx got %0d need 2", lk_idx);
        end
      end
      tlb_lock = 1'b0;
    end
    waitDrain();
  endtask

  task automatic test_back_to_back();
    int ti;
    int td;
    bit ok;
    pulseReset();
    @(negedge clk);
    hitEnable = 1'b1;
    hitIdx    = 6'd2;
    hitExc    = 5'h03;
    d_store   = 1'b1;
    i_req     = 1'b1;
    d_req     = 1'b1;
    @(negedge clk);
    ti = cycle;
    checks++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rr_first_i got i_ack=%b d_ack=%b need 1/0", i_ack, d_ack);
    end
    i_req = 1'b0;
    pushExp(1'b0, 1'b0, 6'd2, 5'h03, ti + 4);
    waitAck(1'b1, td, ok);
    d_req = 1'b0;
    if (ok) begin
      pushExp(1'b1, 1'b0, 6'd2, 5'h03, td + 4);
      checks++;
      if (td !== ti + 5) begin
        failures++;
        $display("[TB] FAIL d_grant_cycle got %0d need %0d", td, ti + 5);
      end
    end
    waitDrain();

    i_req = 1'b1;
    waitAck(1'b0, ti, ok);
    i_req = 1'b0;
    if (ok) pushExp(1'b0, 1'b0, 6'd2, 5'h03, ti + 4);
    waitDrain();

    i_req = 1'b1;
    d_req = 1'b1;
    @(negedge clk);
    td = cycle;
    checks++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rr_first_d got i_ack=%b d_ack=%b need 0/1", i_ack, d_ack);
    end
    d_req = 1'b0;
    pushExp(1'b1, 1'b0, 6'd2, 5'h03, td + 4);
    waitAck(1'b0, ti, ok);
    i_req = 1'b0;
    if (ok) begin
      pushExp(1'b0, 1'b0, 6'd2, 5'h03, ti + 4);
      checks++;
      if (ti !== td + 5) begin
        failures++;
        $display("[TB] FAIL i_grant_cycle got %0d need %0d", ti, td + 5);
      end
    end
    waitDrain();
  endtask

  task automatic test_exc_and_reset();
    int t;
    bit ok;
    @(negedge clk);
    hitEnable = 1'b1;
    hitIdx    = 6'd3;
    hitExc    = 5'h04;
    i_ea      = 32'h0040_2000;
    i_req     = 1'b1;
    waitAck(1'b0, t, ok);
    i_req = 1'b0;
    if (ok) pushExp(1'b0, 1'b0, 6'd3, 5'h04, t + 5);
    waitDrain();

    hitEnable = 1'b0;
    i_req     = 1'b1;
    waitAck(1'b0, t, ok);
    i_req = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (lk_idx !== 6'd10) begin
      failures++;
      $display("[TB] FAIL pre_reset_idx got %0d need 10", lk_idx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, rsp_valid, lk_ifetch, lk_as} !== 4'b0 || lk_idx !== '0 || lk_ea !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midscan_reset got bv_if_as=%b idx=%0d ea=%h need 0",
               {busy, rsp_valid, lk_ifetch, lk_as}, lk_idx, lk_ea);
    end
    checks++;
    if (rsp_idx !== '0 || rsp_exc !== 5'h0) begin
      failures++;
      $display("[TB] FAIL midscan_reset_rsp got idx=%0d exc=%h need 0/00", rsp_idx, rsp_exc);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || lk_idx !== '0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle got busy=%b idx=%0d need 0/0", busy, lk_idx);
    end
  endtask

`ifdef TLB_LOOKUP_MRU_EN
  task automatic test_mru();
    int t;
    bit ok;
    pulseReset();
    @(negedge clk);
    hitEnable = 1'b1;
    hitIdx    = 6'd7;
    hitExc    = 5'h00;
    for (int r = 0; r < 2; r++) begin
      i_req = 1'b1;
      waitAck(1'b0, t, ok);
      i_req = 1'b0;
      if (ok) pushExp(1'b0, 1'b0, 6'd7, 5'h00, t + ((r == 0) ? 10 : 2));
      waitDrain();
    end
    hitIdx = 6'd3;
    i_req  = 1'b1;
    waitAck(1'b0, t, ok);
    i_req = 1'b0;
    if (ok) begin
      pushExp(1'b0, 1'b0, 6'd3, 5'h00, t + 6);
      checks++;
      if (lk_idx !== 6'd7) begin
        failures++;
        $display("[TB] FAIL mru_first_probe got %0d need 7", lk_idx);
      end
    end
    waitDrain();
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    i_req     = 1'b0;
    i_ea      = '0;
    i_as      = 1'b0;
    d_req     = 1'b0;
    d_ea      = '0;
    d_as      = 1'b0;
    d_store   = 1'b0;
    tlb_lock  = 1'b0;
    hitEnable = 1'b0;
    hitIdx    = '0;
    hitExc    = '0;
    test_reset();
    test_ifetch_hit();
    test_data_side();
    test_lock();
    test_back_to_back();
    test_exc_and_reset();
`ifdef TLB_LOOKUP_MRU_EN
    test_mru();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout need completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
